// File: rtl/sqrt_prenorm_pipelined.sv
// Square-root pre-normalizer: even left-shift so the top bit pair is nonzero, with {valid, k, zero} delayed to match the sqrt array.
// Optional saturating sample/zero counters are enabled with SQRT_PRENORM_STATS_EN.
module sqrt_prenorm_pipelined #(
  parameter  int unsigned BITS     = 8,
  parameter  int unsigned SQRT_LAT = 8,
  localparam int unsigned SW       = $clog2(BITS/2)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_x,
  output logic            norm_valid,
  output logic [BITS-1:0] norm_x,
  output logic            aligned_valid,
  output logic [SW-1:0]   aligned_shift,
`ifdef SQRT_PRENORM_STATS_EN
  output logic [15:0]     stat_samples,
  output logic [15:0]     stat_zeros,
`endif
  output logic            aligned_zero
);

  localparam int unsigned LZW = $clog2(BITS + 1);

  logic                         r_s1_valid;
  logic [BITS-1:0]              r_s1_x;
  logic                         r_norm_valid;
  logic [BITS-1:0]              r_norm_x;
  logic [SW-1:0]                r_norm_k;
  logic                         r_norm_zero;
  logic [SQRT_LAT-1:0]          r_dl_valid;
  logic [SQRT_LAT-1:0][SW-1:0]  r_dl_k;
  logic [SQRT_LAT-1:0]          r_dl_zero;

  logic [LZW-1:0]  w_lz;
  logic [SW-1:0]   w_k;
  logic [LZW-1:0]  w_shamt;
  logic            w_zero;
  logic [BITS-1:0] w_norm;

  // Leading-zero count; ascending scan leaves the highest set bit's position last.
  always_comb begin
    w_lz = LZW'(BITS);
    for (int i = 0; i < int'(BITS); i++) begin
      if (r_s1_x[i]) w_lz = LZW'(int'(BITS) - 1 - i);
    end
    w_zero  = (r_s1_x == '0);
    w_k     = w_zero ? '0 : SW'(w_lz >> 1);
    w_shamt = LZW'({w_k, 1'b0});
    w_norm  = r_s1_x << w_shamt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_x       <= '0;
      r_norm_valid <= 1'b0;
      r_norm_x     <= '0;
      r_norm_k     <= '0;
      r_norm_zero  <= 1'b0;
    end else begin
      r_s1_valid   <= in_valid;
      r_s1_x       <= in_x;
      r_norm_valid <= r_s1_valid;
      r_norm_x     <= w_norm;
      r_norm_k     <= w_k;
      r_norm_zero  <= w_zero;
    end
  end

  // Side-band delay line matched to the sqrt array latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dl_valid <= '0;
      r_dl_k     <= '0;
      r_dl_zero  <= '0;
    end else begin
      r_dl_valid[0] <= r_norm_valid;
      r_dl_k[0]     <= r_norm_k;
      r_dl_zero[0]  <= r_norm_zero;
      for (int i = 1; i < int'(SQRT_LAT); i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl_k[i]     <= r_dl_k[i-1];
        r_dl_zero[i]  <= r_dl_zero[i-1];
      end
    end
  end

  assign norm_valid    = r_norm_valid;
  assign norm_x        = r_norm_x;
  assign aligned_valid = r_dl_valid[SQRT_LAT-1];
  assign aligned_shift = r_dl_k[SQRT_LAT-1];
  assign aligned_zero  = r_dl_zero[SQRT_LAT-1];

`ifdef SQRT_PRENORM_STATS_EN
  logic [15:0] r_stat_samples;
  logic [15:0] r_stat_zeros;

  // Saturating counters over normalized-output slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_samples <= '0;
      r_stat_zeros   <= '0;
    end else if (r_norm_valid) begin
      if (r_stat_samples != 16'hFFFF) r_stat_samples <= r_stat_samples + 16'd1;
      if (r_norm_zero && r_stat_zeros != 16'hFFFF) r_stat_zeros <= r_stat_zeros + 16'd1;
    end
  end

  assign stat_samples = r_stat_samples;
  assign stat_zeros   = r_stat_zeros;
`endif

endmodule

// File: tb/tb_sqrt_prenorm_pipelined.sv
// Randomized and directed bench for sqrt_prenorm_pipelined against a per-cycle history reference model.
module tb_sqrt_prenorm_pipelined;

  localparam int unsigned BITS = 8;
  localparam int unsigned LAT  = 8;
  localparam int unsigned SW   = $clog2(BITS/2);
  localparam int HN = 1024;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [BITS-1:0] in_x;
  logic            norm_valid;
  logic [BITS-1:0] norm_x;
  logic            aligned_valid;
  logic [SW-1:0]   aligned_shift;
  logic            aligned_zero;
`ifdef SQRT_PRENORM_STATS_EN
  logic [15:0]     stat_samples;
  logic [15:0]     stat_zeros;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 16;
  logic hv [HN];
  int   hx [HN];

  sqrt_prenorm_pipelined #(.BITS(BITS), .SQRT_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x),
    .norm_valid(norm_valid), .norm_x(norm_x),
    .aligned_valid(aligned_valid), .aligned_shift(aligned_shift),
`ifdef SQRT_PRENORM_STATS_EN
    .stat_samples(stat_samples), .stat_zeros(stat_zeros),
`endif
    .aligned_zero(aligned_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference: multiply by 4 while the result still fits in BITS bits.
  function automatic void ref_norm(input int x, output int nx, output int k, output int z);
    nx = x; k = 0; z = (x == 0) ? 1 : 0;
    if (x != 0)
      while (nx * 4 < (1 << BITS)) begin
        nx = nx * 4;
        k++;
      end
  endfunction

  // Drive one cycle's inputs, then check outputs at the following negedge.
  task automatic tick(input logic v, input int x, input logic rst);
    int nx, k, z, ia, ib;
    rst_n = rst; in_valid = v; in_x = BITS'(x);
    if (!rst) for (int i = 0; i < HN; i++) hv[i] = 1'b0;
    hv[cyc % HN] = v & rst;
    hx[cyc % HN] = x;
    @(negedge clk);
    if (!rst) begin
      check("rst_norm_valid", 32'(norm_valid), 0);
      check("rst_norm_x", 32'(norm_x), 0);
      check("rst_aligned_valid", 32'(aligned_valid), 0);
      check("rst_aligned_shift", 32'(aligned_shift), 0);
      check("rst_aligned_zero", 32'(aligned_zero), 0);
    end else begin
      ia = (cyc - 2) % HN;
      ib = (cyc - 2 - int'(LAT)) % HN;
      check("norm_valid", 32'(norm_valid), 32'(hv[ia]));
      if (hv[ia]) begin
        ref_norm(hx[ia], nx, k, z);
        check("norm_x", 32'(norm_x), 32'(nx));
        check("norm_top_pair", 32'(z == 0 && norm_x[BITS-1 -: 2] == 2'b00), 0);
      end
      check("aligned_valid", 32'(aligned_valid), 32'(hv[ib]));
      if (hv[ib]) begin
        ref_norm(hx[ib], nx, k, z);
        check("aligned_shift", 32'(aligned_shift), 32'(k));
        check("aligned_zero", 32'(aligned_zero), 32'(z));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int dir [5];
    int bub [5];
    dir = '{8'h01, 8'h04, 8'h20, 8'h30, 8'h80};
    bub = '{1, 0, 1, 1, 0};
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0;
    #1;
    for (int i = 0; i < 3; i++) tick(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, dir[i], 1'b1);
    tick(1'b1, 8'h10, 1'b1);
    tick(1'b1, 8'h00, 1'b1);
    tick(1'b1, 8'h03, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'(bub[i]), 8'h05 + i, 1'b1);
    for (int i = 0; i < int'(LAT) + 4; i++) tick(1'b0, 0, 1'b1);
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 12; i++) tick(1'b1, int'($urandom_range(1, 255)), (i == 6) ? 1'b0 : 1'b1);
    for (int i = 0; i < int'(LAT) + 4; i++) tick(1'b0, 0, 1'b1);
`ifdef SQRT_PRENORM_STATS_EN
    tick(1'b0, 0, 1'b0);
    check("stat_samples_rst", 32'(stat_samples), 0);
    check("stat_zeros_rst", 32'(stat_zeros), 0);
    for (int i = 0; i < 70000; i++)
      tick(1'b1, (i == 100 || i == 30000 || i == 69000) ? 0 : int'($urandom_range(1, 255)), 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 0, 1'b1);
    check("stat_samples_sat", 32'(stat_samples), 32'h0000FFFF);
    check("stat_zeros", 32'(stat_zeros), 3);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
